alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Parametrised control-step sequencer for the bus-based CPU datapath. It replaces hand-written per-instruction stimulus. On command it either preloads a general register through MDR, or runs a full fetch/execute sequence for any three-operand or unary ALU instruction. It drives one-hot register in/out strobes, ALU function selects and HI/LO writeback for multiply/divide. It sits between the test or control front end and the datapath control inputs.

## Interface
- DATA_W, 32, datapath word width
- NUM_REGS, 16, general registers (one-hot strobe width)
- REG_ADDR_W, 4, register index width; 2^REG_ADDR_W >= NUM_REGS
- NUM_OPS, 16, ALU functions (one-hot select width)
- MUL_OP, 11, op index that needs HI/LO writeback
- DIV_OP, 12, op index that needs HI/LO writeback
- clock  in  1  single clock, all state updates on rising edge
- clear  in  1  synchronous, active-high reset
- start  in  1  command request, sampled only in IDLE
- cmd  in  1  0 = register load, 1 = execute instruction
- op  in  4  ALU function index
- ra, rb, rc  in  REG_ADDR_W each  destination, source 1, source 2
- unary  in  1  1 = single-source op (NOT/NEG), rc ignored
- data_in  in  DATA_W  load value (cmd 0) or instruction word (cmd 1)
- Mdatain  out  DATA_W  memory data presented to MDR
- Read, MDRin, MDRout, PCout, PCin, IncPC, MARin, IRin, Yin, Zin, Zlowout, Zhighout, LOin, HIin  out  1 each  datapath strobes
- Rin, Rout  out  NUM_REGS  one-hot register strobes
- alu_op  out  NUM_OPS  one-hot ALU function select
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done: bad register index or op

## Operation
- States: IDLE, LD_A, LD_B, T0, T1, T2, T3, T4, T5, T6.
- On start in IDLE, latch cmd, op, ra, rb, rc, unary and data_in. Next state is LD_A for cmd 0 and T0 for cmd 1.
- LD_A: Read, MDRin; Mdatain = latched data.
- LD_B: MDRout, Rin[ra]. Then return to IDLE.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin; Mdatain = latched instruction word.
- T2: MDRout, IRin.
- T3: Rout[rb], Yin.
- T4: Rout[rc], or Rout[rb] if unary; alu_op[op], Zin.
- T5: if op is MUL_OP or DIV_OP, drive Zlowout and LOin, then go to T6. Otherwise drive Zlowout and Rin[ra], then go to IDLE.
- T6: Zhighout, HIin. Then go to IDLE.
- All strobes are Moore-decoded from the state register only. Every strobe is 0 in IDLE. At most one of Rout bits, and at most one of the Z/MDR/PC bus drivers, is high in any cycle.
- Mdatain is 0 outside LD_A and T1.
- Out-of-range register index (>= NUM_REGS) or op (>= NUM_OPS):
  - the corresponding one-hot vector stays all-zero;
  - the sequence still runs to completion;
  - err is set with done.
- start while busy is ignored; it is not queued.

## Timing
- Reset values: state IDLE, all outputs 0 (including busy, done, err and Mdatain), latched fields 0.
- clear has priority over everything. Mid-sequence it returns to IDLE on that edge with no done pulse and no further strobes.
- Let edge 0 be the edge that samples start. The command's first state occupies cycle 1.
- Load: LD_A in cycle 1, LD_B in cycle 2. done and IDLE in cycle 3.
- Execute: T0–T5 in cycles 1–6; done in cycle 7. MUL/DIV adds T6 in cycle 7; done in cycle 8.
- done and err are registered, high for exactly the one cycle after the final state. busy is 0 in that cycle.
- A new start may be sampled in the done cycle. Back-to-back commands therefore have a 1-cycle gap.

## Test plan
- Load R6: cmd 0, ra 6, data 0x12.
  - Cycle 1: Read=MDRin=1, Mdatain 0x12.
  - Cycle 2: MDRout=1, Rin=0x0040.
  - Cycle 3: done=1, err=0.
- AND R1,R6,R7: cmd 1, op 2, ra 1, rb 6, rc 7, instruction word 0x5.
  - Cycle 2: Mdatain 0x5.
  - Cycle 4: Rout 0x0040, Yin.
  - Cycle 5: Rout 0x0080, alu_op 0x0004.
  - Cycle 6: Zlowout, Rin 0x0002.
  - Cycle 7: done.
- NOT R1,R7: unary 1, rb 7, rc 3.
  - Cycle 5: Rout 0x0080 (rc ignored).
- MUL R6,R7: op 11.
  - Cycle 6: Zlowout, LOin; Rin 0.
  - Cycle 7: Zhighout, HIin.
  - Cycle 8: done.
- Errors and ignored start:
  - NUM_REGS=8 with rb 9: Rout all-zero in cycle 4; done=err=1 in cycle 7.
  - start pulsed in cycle 3 while busy: ignored.
- clear asserted in cycle 4 of an execute: IDLE with all outputs 0 from cycle 5; done never pulses. A following load completes normally.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Control-step sequencer for the bus-based CPU datapath.
// Runs register preloads and fetch/execute sequences for ALU instructions.
module alu_op_sequencer #(
  parameter int DATA_W     = 32,
  parameter int NUM_REGS   = 16,
  parameter int REG_ADDR_W = 4,
  parameter int NUM_OPS    = 16,
  parameter int MUL_OP     = 11,
  parameter int DIV_OP     = 12
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  cmd,
  input  logic [3:0]            op,
  input  logic [REG_ADDR_W-1:0] ra,
  input  logic [REG_ADDR_W-1:0] rb,
  input  logic [REG_ADDR_W-1:0] rc,
  input  logic                  unary,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     Mdatain,
  output logic                  Read,
  output logic                  MDRin,
  output logic                  MDRout,
  output logic                  PCout,
  output logic                  PCin,
  output logic                  IncPC,
  output logic                  MARin,
  output logic                  IRin,
  output logic                  Yin,
  output logic                  Zin,
  output logic                  Zlowout,
  output logic                  Zhighout,
  output logic                  LOin,
  output logic                  HIin,
  output logic [NUM_REGS-1:0]   Rin,
  output logic [NUM_REGS-1:0]   Rout,
  output logic [NUM_OPS-1:0]    alu_op,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [3:0] {
    IDLE, LD_A, LD_B, T0, T1, T2, T3, T4, T5, T6
  } state_t;

  state_t state, state_nx;

  logic [3:0]            op_q;
  logic [REG_ADDR_W-1:0] ra_q, rb_q, rc_q;
  logic                  unary_q;
  logic [DATA_W-1:0]     data_q;
  logic                  muldiv, bad, last;

  function automatic logic [NUM_REGS-1:0] reg_hot(
    input logic [REG_ADDR_W-1:0] idx
  );
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (idx == REG_ADDR_W'(i)) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [NUM_OPS-1:0] op_hot(input logic [3:0] idx);
    logic [NUM_OPS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_OPS; i++)
      if (idx == 4'(i)) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic reg_bad(input logic [REG_ADDR_W-1:0] idx);
    return 32'(idx) >= NUM_REGS;
  endfunction

  assign muldiv = (op_q == 4'(MUL_OP)) || (op_q == 4'(DIV_OP));

  // Only indices the sequence actually strobes can flag an error.
  assign bad = (state == LD_B) ? reg_bad(ra_q) :
               (32'(op_q) >= NUM_OPS) | reg_bad(rb_q) |
               (!unary_q & reg_bad(rc_q)) |
               (!muldiv & reg_bad(ra_q));

  assign last = (state == LD_B) || (state == T6) ||
                (state == T5 && !muldiv);

  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      unary_q <= 1'b0;
      data_q  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= last;
      err   <= last & bad;
      if (state == IDLE && start) begin
        op_q    <= op;
        ra_q    <= ra;
        rb_q    <= rb;
        rc_q    <= rc;
        unary_q <= unary;
        data_q  <= data_in;
      end
    end
  end

  always_comb begin
    state_nx = state;
    Mdatain  = '0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    Rin      = '0;
    Rout     = '0;
    alu_op   = '0;
    busy     = (state != IDLE);
    unique case (state)
      IDLE: if (start) state_nx = cmd ? T0 : LD_A;
      LD_A: begin
        Read     = 1'b1;
        MDRin    = 1'b1;
        Mdatain  = data_q;
        state_nx = LD_B;
      end
      LD_B: begin
        MDRout   = 1'b1;
        Rin      = reg_hot(ra_q);
        state_nx = IDLE;
      end
      T0: begin
        PCout    = 1'b1;
        MARin    = 1'b1;
        IncPC    = 1'b1;
        Zin      = 1'b1;
        state_nx = T1;
      end
      T1: begin
        Zlowout  = 1'b1;
        PCin     = 1'b1;
        Read     = 1'b1;
        MDRin    = 1'b1;
        Mdatain  = data_q;
        state_nx = T2;
      end
      T2: begin
        MDRout   = 1'b1;
        IRin     = 1'b1;
        state_nx = T3;
      end
      T3: begin
        Rout     = reg_hot(rb_q);
        Yin      = 1'b1;
        state_nx = T4;
      end
      T4: begin
        Rout     = reg_hot(unary_q ? rb_q : rc_q);
        alu_op   = op_hot(op_q);
        Zin      = 1'b1;
        state_nx = T5;
      end
      T5: begin
        Zlowout = 1'b1;
        if (muldiv) begin
          LOin     = 1'b1;
          state_nx = T6;
        end else begin
          Rin      = reg_hot(ra_q);
          state_nx = IDLE;
        end
      end
      T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: random and directed commands,
// expected per-cycle strobe snapshots queued at issue, checked by a monitor.
module tb_alu_op_sequencer;

  localparam int NR = 12;
  localparam int NO = 14;
  localparam int MULI = 11;
  localparam int DIVI = 12;

  typedef struct packed {
    logic [31:0]   mdat;
    logic          read, mdrin, mdrout, pcout, pcin, incpc, marin;
    logic          irin, yin, zin, zlo, zhi, loin, hiin;
    logic [NR-1:0] rin;
    logic [NR-1:0] rout;
    logic [NO-1:0] alu;
    logic          busy, done, err;
  } snap_t;

  logic        clock = 1'b0;
  logic        clear, start, cmd, unary;
  logic [3:0]  op, ra, rb, rc;
  logic [31:0] data_in, Mdatain;
  logic Read, MDRin, MDRout, PCout, PCin, IncPC, MARin, IRin;
  logic Yin, Zin, Zlowout, Zhighout, LOin, HIin, busy, done, err;
  logic [NR-1:0] Rin, Rout;
  logic [NO-1:0] alu_op;

  snap_t sbq[$];
  snap_t act;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  alu_op_sequencer #(.NUM_REGS(NR), .NUM_OPS(NO)) dut (
    .clock(clock), .clear(clear), .start(start), .cmd(cmd), .op(op),
    .ra(ra), .rb(rb), .rc(rc), .unary(unary), .data_in(data_in),
    .Mdatain(Mdatain), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin), .Rin(Rin),
    .Rout(Rout), .alu_op(alu_op), .busy(busy), .done(done), .err(err)
  );

  assign act = {Mdatain, Read, MDRin, MDRout, PCout, PCin, IncPC, MARin,
                IRin, Yin, Zin, Zlowout, Zhighout, LOin, HIin,
                Rin, Rout, alu_op, busy, done, err};

  function automatic logic [NR-1:0] rhot(input int i);
    logic [31:0] w;
    w = (i < NR) ? (32'd1 << i) : 32'd0;
    return w[NR-1:0];
  endfunction

  function automatic logic [NO-1:0] ohot(input int i);
    logic [31:0] w;
    w = (i < NO) ? (32'd1 << i) : 32'd0;
    return w[NO-1:0];
  endfunction

  // Reference: list the control steps of the command, one snapshot per cycle.
  task automatic push_cmd(input logic c, input int o, input int a,
                          input int b, input int cc, input logic u,
                          input logic [31:0] d, output int len);
    snap_t s;
    bit md, bad;
    md = (o == MULI) || (o == DIVI);
    if (!c) begin
      s = '0; s.busy = 1; s.read = 1; s.mdrin = 1; s.mdat = d;
      sbq.push_back(s);
      s = '0; s.busy = 1; s.mdrout = 1; s.rin = rhot(a);
      sbq.push_back(s);
      bad = (a >= NR);
      len = 2;
    end else begin
      s = '0; s.busy = 1; s.pcout = 1; s.marin = 1; s.incpc = 1; s.zin = 1;
      sbq.push_back(s);
      s = '0; s.busy = 1; s.zlo = 1; s.pcin = 1; s.read = 1; s.mdrin = 1;
      s.mdat = d;
      sbq.push_back(s);
      s = '0; s.busy = 1; s.mdrout = 1; s.irin = 1;
      sbq.push_back(s);
      s = '0; s.busy = 1; s.rout = rhot(b); s.yin = 1;
      sbq.push_back(s);
      s = '0; s.busy = 1; s.rout = rhot(u ? b : cc); s.alu = ohot(o);
      s.zin = 1;
      sbq.push_back(s);
      s = '0; s.busy = 1; s.zlo = 1;
      if (md) s.loin = 1;
      else s.rin = rhot(a);
      sbq.push_back(s);
      len = 6;
      if (md) begin
        s = '0; s.busy = 1; s.zhi = 1; s.hiin = 1;
        sbq.push_back(s);
        len = 7;
      end
      bad = (o >= NO) || (b >= NR) || (!u && cc >= NR) || (!md && a >= NR);
    end
    s = '0; s.done = 1; s.err = bad;
    sbq.push_back(s);
  endtask

  // Entered at posedge+1 of an idle/done cycle; returns in the done cycle
  // (plus gap idle cycles).
  task automatic run(input logic c, input int o, input int a, input int b,
                     input int cc, input logic u, input logic [31:0] d,
                     input int gap, input bit poke);
    int len;
    cmd = c; op = 4'(o); ra = 4'(a); rb = 4'(b); rc = 4'(cc);
    unary = u; data_in = d; start = 1;
    push_cmd(c, o, a, b, cc, u, d, len);
    @(posedge clock); #1;
    for (int k = 1; k <= len; k++) begin
      start = 0;
      if (poke && k == 3) begin
        start = 1; cmd = 0; ra = 4'($urandom_range(0, 15));
        data_in = $urandom;
      end
      @(posedge clock); #1;
    end
    start = 0;
    repeat (gap) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    @(posedge clock);
    forever begin
      @(negedge clock);
      n_chk++;
      if (busy || done) begin
        if (sbq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got %h want nothing", act);
        end else begin
          snap_t e;
          e = sbq.pop_front();
          if (act !== e) begin
            n_fail++;
            $display("FAIL step @%0t: got %h want %h", $time, act, e);
          end
        end
      end else if (act !== snap_t'(0)) begin
        n_fail++;
        $display("FAIL idle @%0t: got %h want 0", $time, act);
      end
    end
  end

  initial begin
    clear = 1; start = 0; cmd = 0; op = 0; ra = 0; rb = 0; rc = 0;
    unary = 0; data_in = 0;
    repeat (3) @(posedge clock);
    #1 clear = 0;
    @(posedge clock); #1;
    run(0, 0, 6, 0, 0, 0, 32'h12, 0, 0);
    run(1, 2, 1, 6, 7, 0, 32'h5, 0, 1);
    run(1, 9, 1, 7, 3, 1, 32'h77, 1, 0);
    run(1, MULI, 0, 6, 7, 0, 32'h1234, 0, 0);
    run(1, DIVI, 15, 2, 3, 0, 32'hdead, 0, 1);
    run(1, 2, 1, 13, 7, 0, 32'h9, 0, 0);
    run(1, 15, 1, 2, 3, 0, 32'ha, 0, 0);
    run(0, 0, 14, 0, 0, 0, 32'hbeef, 2, 0);
    begin : clear_mid
      int len;
      cmd = 1; op = 2; ra = 1; rb = 6; rc = 7; unary = 0;
      data_in = 32'h5; start = 1;
      push_cmd(1, 2, 1, 6, 7, 0, 32'h5, len);
      @(posedge clock); #1 start = 0;
      repeat (3) @(posedge clock);
      #1 clear = 1;
      @(posedge clock); #1 clear = 0;
      sbq.delete();
      @(posedge clock); #1;
    end
    run(0, 0, 3, 0, 0, 0, 32'hcafe, 0, 0);
    for (int i = 0; i < 200; i++)
      run($urandom_range(0, 1), $urandom_range(0, 15),
          $urandom_range(0, 15), $urandom_range(0, 15),
          $urandom_range(0, 15), $urandom_range(0, 1), $urandom,
          $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
    repeat (3) @(posedge clock);
    #1;
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
